// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard detection and operand-forwarding controller for the 5-stage RV32I
// pipeline. It keeps its own shadow copy of the register fields of the
// instructions in EX, MEM and WB. From these it derives:
//   * the EX-stage 3:1 operand-forwarding mux selects,
//   * the control-zeroing (bubble) select for the ID/EX register,
//   * the PC / IF-ID enables and the IF-ID flush,
//   * stall and flush performance counters.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   id_valid            ID stage holds a real instruction
//   id_rs1/id_rs2       ID source registers, id_rs1_used/id_rs2_used mark reads
//   id_rd               ID destination register
//   id_reg_write        ID instruction writes rd
//   id_mem_read         ID instruction is a load
//   branch_taken        EX resolved a taken branch/jump this cycle
//   fwd_sel_a/b         00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result
//   ctrl_flush          zero the ID/EX control word (bubble)
//   pc_write            PC enable
//   ifid_write          IF/ID enable
//   ifid_flush          clear IF/ID to NOP
//   stall_cnt           load-use stall cycles
//   flush_cnt           taken-branch flush cycles
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_taken,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  ctrl_flush,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Shadow of the register-related fields of one pipeline stage.
  // An all-zero slot behaves exactly like an empty stage.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
  } slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  slot_t r_ex;
  slot_t r_mem;
  slot_t r_wb;

  slot_t      w_id_slot;
  logic       w_load_use;
  logic       w_bubble;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Forwarding priority: MEM holds the newest producer, so it beats WB.
  // x0 is hard-wired zero and is never forwarded.
  function automatic logic [1:0] fwdSel(input logic                  used,
                                        input logic [REG_ADDR_W-1:0] rs,
                                        input slot_t                 mem,
                                        input slot_t                 wb);
    logic [1:0] sel;
    sel = SEL_RF;
    if (used && (rs != '0)) begin
      if (mem.reg_write && (mem.rd == rs)) begin
        sel = SEL_MEM;
      end else if (wb.reg_write && (wb.rd == rs)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  // Side-effect bits of an invalid ID slot are masked so it enters EX as a
  // harmless empty slot.
  always_comb begin
    w_id_slot           = '0;
    w_id_slot.rd        = id_rd;
    w_id_slot.reg_write = id_reg_write & id_valid;
    w_id_slot.mem_read  = id_mem_read & id_valid;
    w_id_slot.rs1       = id_rs1;
    w_id_slot.rs2       = id_rs2;
    w_id_slot.rs1_used  = id_rs1_used & id_valid;
    w_id_slot.rs2_used  = id_rs2_used & id_valid;
  end

  // A load in EX whose result the ID instruction needs cannot be forwarded in
  // time, so one stall cycle is required.
  assign w_load_use = id_valid && r_ex.mem_read && (r_ex.rd != '0) &&
                      ((id_rs1_used && (id_rs1 == r_ex.rd)) ||
                       (id_rs2_used && (id_rs2 == r_ex.rd)));

  // A taken branch also squashes the ID instruction, so both cases bubble EX.
  assign w_bubble = branch_taken | w_load_use;

  assign w_fwd_a = fwdSel(r_ex.rs1_used, r_ex.rs1, r_mem, r_wb);
  assign w_fwd_b = fwdSel(r_ex.rs2_used, r_ex.rs2, r_mem, r_wb);

  // Output decode. While rst is high the outputs are forced to the idle
  // values immediately, independent of the branch_taken input.
  always_comb begin
    fwd_sel_a  = w_fwd_a;
    fwd_sel_b  = w_fwd_b;
    ctrl_flush = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    if (rst) begin
      fwd_sel_a = SEL_RF;
      fwd_sel_b = SEL_RF;
    end else if (branch_taken) begin
      ctrl_flush = 1'b1;
      ifid_flush = 1'b1;
    end else if (w_load_use) begin
      ctrl_flush = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  // Slots advance every cycle; there is no back-end stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_bubble ? slot_t'('0) : w_id_slot;
    end
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (w_load_use && !branch_taken) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (branch_taken) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//
// Directed instruction sequences are driven into the ID-side inputs one cycle
// at a time. Each cycle's hand-computed expected outputs are pushed into a
// queue; a separate monitor pops one entry per falling edge and compares.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  localparam int RW = 5;
  localparam int CW = 32;

  typedef struct {
    logic          v;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
  } instr_t;

  typedef struct {
    string         name;
    logic [1:0]    a;
    logic [1:0]    b;
    logic          cf;
    logic          pw;
    logic          iw;
    logic          ifl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          idValid;
  logic [RW-1:0] idRs1;
  logic [RW-1:0] idRs2;
  logic          idRs1Used;
  logic          idRs2Used;
  logic [RW-1:0] idRd;
  logic          idRegWrite;
  logic          idMemRead;
  logic          branchTaken;
  logic [1:0]    fwdSelA;
  logic [1:0]    fwdSelB;
  logic          ctrlFlush;
  logic          pcWrite;
  logic          ifidWrite;
  logic          ifidFlush;
  logic [CW-1:0] stallCnt;
  logic [CW-1:0] flushCnt;

  exp_t expQ[$];
  int   numChecks = 0;
  int   numFails  = 0;

  hazard_fwd_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (idValid),
    .id_rs1       (idRs1),
    .id_rs2       (idRs2),
    .id_rs1_used  (idRs1Used),
    .id_rs2_used  (idRs2Used),
    .id_rd        (idRd),
    .id_reg_write (idRegWrite),
    .id_mem_read  (idMemRead),
    .branch_taken (branchTaken),
    .fwd_sel_a    (fwdSelA),
    .fwd_sel_b    (fwdSelB),
    .ctrl_flush   (ctrlFlush),
    .pc_write     (pcWrite),
    .ifid_write   (ifidWrite),
    .ifid_flush   (ifidFlush),
    .stall_cnt    (stallCnt),
    .flush_cnt    (flushCnt)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction builders: ALU op, load, and an empty ID slot.
  function automatic instr_t alu(input int rd, input int rs1, input int rs2);
    instr_t i;
    i = '{v: 1'b1, rs1: RW'(rs1), rs2: RW'(rs2), u1: 1'b1, u2: 1'b1,
          rd: RW'(rd), rw: 1'b1, mr: 1'b0};
    return i;
  endfunction

  function automatic instr_t load(input int rd, input int rs1);
    instr_t i;
    i = '{v: 1'b1, rs1: RW'(rs1), rs2: '0, u1: 1'b1, u2: 1'b0,
          rd: RW'(rd), rw: 1'b1, mr: 1'b1};
    return i;
  endfunction

  function automatic instr_t nop();
    instr_t i;
    i = '{v: 1'b0, rs1: '0, rs2: '0, u1: 1'b0, u2: 1'b0,
          rd: '0, rw: 1'b0, mr: 1'b0};
    return i;
  endfunction

  // Expected output vector builders: general, and the no-hazard case.
  function automatic exp_t mkExp(input string n, input logic [1:0] a, input logic [1:0] b,
                                 input logic cf, input logic pw, input logic iw,
                                 input logic ifl, input int sc, input int fc);
    exp_t e;
    e = '{name: n, a: a, b: b, cf: cf, pw: pw, iw: iw, ifl: ifl,
          sc: CW'(sc), fc: CW'(fc)};
    return e;
  endfunction

  function automatic exp_t norm(input string n, input logic [1:0] a, input logic [1:0] b,
                                input int sc, input int fc);
    return mkExp(n, a, b, 1'b0, 1'b1, 1'b1, 1'b0, sc, fc);
  endfunction

  function automatic exp_t rstExp(input string n);
    return mkExp(n, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
  endfunction

  // One cycle of stimulus: drive just after the rising edge, queue the
  // expectation for this cycle. rstMid raises reset part-way into the cycle,
  // before the monitor samples and with no clock edge in between.
  task automatic applyStimulus(input instr_t ins, input logic bt, input logic rstLevel,
                               input logic rstMid, input exp_t e);
    @(posedge clk);
    #1;
    rst         = rstLevel;
    idValid     = ins.v;
    idRs1       = ins.rs1;
    idRs2       = ins.rs2;
    idRs1Used   = ins.u1;
    idRs2Used   = ins.u2;
    idRd        = ins.rd;
    idRegWrite  = ins.rw;
    idMemRead   = ins.mr;
    branchTaken = bt;
    expQ.push_back(e);
    if (rstMid) begin
      #2;
      rst = 1'b1;
    end
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [CW-1:0] act, input logic [CW-1:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField(e.name, "fwd_sel_a",  CW'(fwdSelA),   CW'(e.a));
    checkField(e.name, "fwd_sel_b",  CW'(fwdSelB),   CW'(e.b));
    checkField(e.name, "ctrl_flush", CW'(ctrlFlush), CW'(e.cf));
    checkField(e.name, "pc_write",   CW'(pcWrite),   CW'(e.pw));
    checkField(e.name, "ifid_write", CW'(ifidWrite), CW'(e.iw));
    checkField(e.name, "ifid_flush", CW'(ifidFlush), CW'(e.ifl));
    checkField(e.name, "stall_cnt",  stallCnt,       e.sc);
    checkField(e.name, "flush_cnt",  flushCnt,       e.fc);
  endtask

  // Monitor: one queued expectation per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Stimulus sequence.
  initial begin
    rst         = 1'b1;
    idValid     = 1'b0;
    idRs1       = '0;
    idRs2       = '0;
    idRs1Used   = 1'b0;
    idRs2Used   = 1'b0;
    idRd        = '0;
    idRegWrite  = 1'b0;
    idMemRead   = 1'b0;
    branchTaken = 1'b0;

    // Reset holds idle outputs even with a taken branch asserted.
    applyStimulus(alu(6, 5, 1), 1'b1, 1'b1, 1'b0, rstExp("R0"));
    applyStimulus(alu(6, 5, 1), 1'b1, 1'b1, 1'b0, rstExp("R1"));

    // lw x5 ; add x6,x5,x1 -> one stall, then MEM/WB forward.
    applyStimulus(load(5, 2),   1'b0, 1'b0, 1'b0, norm("C1_lw", 2'b00, 2'b00, 0, 0));
    applyStimulus(alu(6, 5, 1), 1'b0, 1'b0, 1'b0,
                  mkExp("C2_stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
    applyStimulus(alu(6, 5, 1), 1'b0, 1'b0, 1'b0, norm("C3_held", 2'b00, 2'b00, 1, 0));
    applyStimulus(nop(),        1'b0, 1'b0, 1'b0, norm("C4_fwdwb", 2'b10, 2'b00, 1, 0));

    // add x3 ; sub x4,x3,x3 -> EX/MEM forward on both operands.
    applyStimulus(alu(3, 1, 2), 1'b0, 1'b0, 1'b0, norm("C5_add3", 2'b00, 2'b00, 1, 0));
    applyStimulus(alu(4, 3, 3), 1'b0, 1'b0, 1'b0, norm("C6_sub", 2'b00, 2'b00, 1, 0));
    applyStimulus(nop(),        1'b0, 1'b0, 1'b0, norm("C7_fwdmem", 2'b01, 2'b01, 1, 0));

    // add x3 ; add x3 ; or x7,x3,x0 -> newest (MEM) wins, x0 stays regfile.
    applyStimulus(alu(3, 1, 1), 1'b0, 1'b0, 1'b0, norm("C8_add3a", 2'b00, 2'b00, 1, 0));
    applyStimulus(alu(3, 2, 2), 1'b0, 1'b0, 1'b0, norm("C9_add3b", 2'b00, 2'b00, 1, 0));
    applyStimulus(alu(7, 3, 0), 1'b0, 1'b0, 1'b0, norm("C10_or", 2'b00, 2'b00, 1, 0));
    applyStimulus(nop(),        1'b0, 1'b0, 1'b0, norm("C11_newest", 2'b01, 2'b00, 1, 0));

    // Writes and a load to x0, then a reader of x0: no forward, no stall.
    applyStimulus(alu(0, 1, 1), 1'b0, 1'b0, 1'b0, norm("C12_addx0", 2'b00, 2'b00, 1, 0));
    applyStimulus(load(0, 1),   1'b0, 1'b0, 1'b0, norm("C13_lwx0", 2'b00, 2'b00, 1, 0));
    applyStimulus(alu(8, 0, 0), 1'b0, 1'b0, 1'b0, norm("C14_nostall", 2'b00, 2'b00, 1, 0));
    applyStimulus(nop(),        1'b0, 1'b0, 1'b0, norm("C15_nofwdx0", 2'b00, 2'b00, 1, 0));

    // Load-use pair coinciding with a taken branch: flush, no stall.
    applyStimulus(load(9, 2),   1'b0, 1'b0, 1'b0, norm("C16_lw9", 2'b00, 2'b00, 1, 0));
    applyStimulus(alu(10, 9, 9), 1'b1, 1'b0, 1'b0,
                  mkExp("C17_branch", 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0));
    applyStimulus(nop(),        1'b0, 1'b0, 1'b0, norm("C18_after", 2'b00, 2'b00, 1, 1));

    // Reset asserted during a load-use stall.
    applyStimulus(load(11, 2),  1'b0, 1'b0, 1'b0, norm("C19_lw11", 2'b00, 2'b00, 1, 1));
    applyStimulus(alu(12, 11, 0), 1'b0, 1'b0, 1'b1, rstExp("C20_asyncrst"));
    applyStimulus(alu(12, 11, 0), 1'b0, 1'b1, 1'b0, rstExp("C21_inrst"));
    applyStimulus(alu(12, 11, 0), 1'b0, 1'b0, 1'b0, norm("C22_release", 2'b00, 2'b00, 0, 0));
    applyStimulus(alu(13, 11, 11), 1'b0, 1'b0, 1'b0, norm("C23_clean", 2'b00, 2'b00, 0, 0));
    applyStimulus(nop(),        1'b0, 1'b0, 1'b0, norm("C24_nofwd", 2'b00, 2'b00, 0, 0));

    // Bounded drain of the scoreboard.
    repeat (3) @(posedge clk);
    numChecks++;
    if (expQ.size() != 0) begin
      numFails++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
